// File: rtl/m_store_buffer.sv
// m_store_buffer: M-stage write-posting store buffer ahead of the data memory.
// Queues stores in program order, drains the head entry into the DM write
// port, merges byte stores into the newest queued word, and raises Stall when
// a store finds no slot or a load targets a word that is still queued.
module m_store_buffer #(
   parameter int DEPTH = 4,
   parameter int PTR_W = 2
) (
   input  logic        Clk,
   input  logic        Reset,
   input  logic        St_Req,
   input  logic [31:0] St_Addr,
   input  logic [31:0] St_Data,
   input  logic [3:0]  St_BE,
   input  logic [31:0] St_PC,
   input  logic        Ld_Req,
   input  logic [31:0] Ld_Addr,
   input  logic        DM_Ready,
   output logic        DM_Wr,
   output logic [31:0] DM_Addr,
   output logic [31:0] DM_Data,
   output logic [3:0]  DM_BE,
   output logic [31:0] DM_PC,
   output logic        Stall,
   output logic        Empty,
   output logic        Full
);

   localparam logic [PTR_W:0] LP_DEPTH = (PTR_W+1)'(DEPTH);
   localparam logic [PTR_W:0] LP_ONE   = (PTR_W+1)'(1);

   // Entry storage
   logic [29:0]      r_addr [DEPTH];
   logic [31:0]      r_data [DEPTH];
   logic [3:0]       r_be   [DEPTH];
   logic [31:0]      r_pc   [DEPTH];

   // Queue bookkeeping
   logic [PTR_W-1:0] r_head;
   logic [PTR_W-1:0] r_tail;
   logic [PTR_W:0]   r_count;

   // Combinational control
   logic             w_empty;
   logic             w_full;
   logic             w_drain;
   logic [PTR_W-1:0] w_last;
   logic             w_st_valid;
   logic             w_merge;
   logic             w_alloc;
   logic             w_ld_hit;
   logic [PTR_W-1:0] w_off;

   assign w_empty    = (r_count == '0);
   assign w_full     = (r_count == LP_DEPTH);
   assign w_drain    = !w_empty && DM_Ready;
   assign w_last     = r_tail - 1'b1;
   // A store with no byte enables is not a store at all
   assign w_st_valid = St_Req && (St_BE != 4'h0);

   // Merging into the head while it is being drained would lose the new
   // bytes, so that case falls through to a fresh allocation instead.
   assign w_merge = w_st_valid && !w_empty
                    && (St_Addr[31:2] == r_addr[w_last])
                    && !((r_count == LP_ONE) && w_drain);
   assign w_alloc = w_st_valid && !w_merge && (!w_full || w_drain);

   // Load hazard: compare against every live entry, including the head being drained
   always_comb begin
      w_ld_hit = 1'b0;
      w_off    = '0;
      for (int unsigned i = 0; i < DEPTH; i++) begin
         w_off = PTR_W'(i) - r_head;
         if (({1'b0, w_off} < r_count) && (r_addr[i] == Ld_Addr[31:2])) begin
            w_ld_hit = 1'b1;
         end
      end
   end

   assign Stall   = (w_st_valid && w_full && !w_drain && !w_merge) || (Ld_Req && w_ld_hit);
   assign Empty   = w_empty;
   assign Full    = w_full;
   assign DM_Wr   = !w_empty;
   assign DM_Addr = {r_addr[r_head], 2'b00};
   assign DM_Data = r_data[r_head];
   assign DM_BE   = r_be[r_head];
   assign DM_PC   = r_pc[r_head];

   // Pointer and occupancy update; drain and allocate may happen together
   always_ff @(posedge Clk or posedge Reset) begin
      if (Reset) begin
         r_head  <= '0;
         r_tail  <= '0;
         r_count <= '0;
      end else begin
         if (w_drain) begin
            r_head <= r_head + 1'b1;
         end
         if (w_alloc) begin
            r_tail <= r_tail + 1'b1;
         end
         case ({w_alloc, w_drain})
            2'b10:   r_count <= r_count + 1'b1;
            2'b01:   r_count <= r_count - 1'b1;
            default: r_count <= r_count;
         endcase
      end
   end

   // Byte enables are cleared on reset so the head reads as an empty write
   always_ff @(posedge Clk or posedge Reset) begin
      if (Reset) begin
         for (int unsigned i = 0; i < DEPTH; i++) begin
            r_be[i] <= '0;
         end
      end else if (w_alloc) begin
         r_be[r_tail] <= St_BE;
      end else if (w_merge) begin
         r_be[w_last] <= r_be[w_last] | St_BE;
      end
   end

   // Address, data and PC payload; only meaningful while an entry is live
   always_ff @(posedge Clk) begin
      if (w_alloc) begin
         r_addr[r_tail] <= St_Addr[31:2];
         r_data[r_tail] <= St_Data;
         r_pc[r_tail]   <= St_PC;
      end else if (w_merge) begin
         r_pc[w_last] <= St_PC;
         for (int unsigned i = 0; i < 4; i++) begin
            if (St_BE[i]) begin
               r_data[w_last][8*i +: 8] <= St_Data[8*i +: 8];
            end
         end
      end
   end

endmodule

// File: tb/tb_m_store_buffer.sv
// tb_m_store_buffer: directed checks of m_store_buffer enqueue, drain, merge,
// full/stall, load hazard, wrap-around and asynchronous reset behaviour.
module tb_m_store_buffer;

   logic        Clk = 1'b0;
   logic        Reset;
   logic        St_Req;
   logic [31:0] St_Addr;
   logic [31:0] St_Data;
   logic [3:0]  St_BE;
   logic [31:0] St_PC;
   logic        Ld_Req;
   logic [31:0] Ld_Addr;
   logic        DM_Ready;
   logic        DM_Wr;
   logic [31:0] DM_Addr;
   logic [31:0] DM_Data;
   logic [3:0]  DM_BE;
   logic [31:0] DM_PC;
   logic        Stall;
   logic        Empty;
   logic        Full;

   int n_chk  = 0;
   int n_fail = 0;

   logic [31:0] exp_addr [4];
   logic [31:0] exp_data [4];

   m_store_buffer #(.DEPTH(4), .PTR_W(2)) u_dut (
      .Clk      (Clk),
      .Reset    (Reset),
      .St_Req   (St_Req),
      .St_Addr  (St_Addr),
      .St_Data  (St_Data),
      .St_BE    (St_BE),
      .St_PC    (St_PC),
      .Ld_Req   (Ld_Req),
      .Ld_Addr  (Ld_Addr),
      .DM_Ready (DM_Ready),
      .DM_Wr    (DM_Wr),
      .DM_Addr  (DM_Addr),
      .DM_Data  (DM_Data),
      .DM_BE    (DM_BE),
      .DM_PC    (DM_PC),
      .Stall    (Stall),
      .Empty    (Empty),
      .Full     (Full)
   );

   always #5 Clk = ~Clk;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_chk++;
      if (obs !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
      end
   endtask

   // Advance one clock; inputs change and outputs settle 1 time unit after the edge
   task automatic step();
      @(posedge Clk);
      #1;
   endtask

   task automatic store(input logic [31:0] a, input logic [31:0] d,
                        input logic [3:0] be, input logic [31:0] pc);
      St_Req  = 1'b1;
      St_Addr = a;
      St_Data = d;
      St_BE   = be;
      St_PC   = pc;
   endtask

   initial begin
      Reset = 1'b1; St_Req = 1'b0; St_Addr = '0; St_Data = '0; St_BE = '0;
      St_PC = '0; Ld_Req = 1'b0; Ld_Addr = '0; DM_Ready = 1'b0;
      step(); step();
      check("rst_empty", 32'(Empty), 32'd1);
      check("rst_full",  32'(Full),  32'd0);
      check("rst_wr",    32'(DM_Wr), 32'd0);
      check("rst_stall", 32'(Stall), 32'd0);
      check("rst_be",    32'(DM_BE), 32'd0);
      Reset = 1'b0;

      // Single store, empty queue: visible the next cycle, then drained
      DM_Ready = 1'b1;
      store(32'h10, 32'h1234_5678, 4'hF, 32'h100);
      #1 check("t1_no_bypass", 32'(DM_Wr), 32'd0);
      step();
      St_Req = 1'b0;
      check("t1_wr",   32'(DM_Wr), 32'd1);
      check("t1_addr", DM_Addr, 32'h10);
      check("t1_data", DM_Data, 32'h1234_5678);
      check("t1_be",   32'(DM_BE), 32'hF);
      check("t1_pc",   DM_PC, 32'h100);
      step();
      check("t1_empty", 32'(Empty), 32'd1);
      check("t1_wr0",   32'(DM_Wr), 32'd0);

      // Fill to full, hazard on a non-head entry, merge while full, wrap
      DM_Ready = 1'b0;
      for (int k = 0; k < 4; k++) begin
         store(32'(4*k), 32'hA0 + 32'(k), 4'hF, 32'h200 + 32'(4*k));
         step();
      end
      St_Req = 1'b0;
      check("t2_full", 32'(Full), 32'd1);
      Ld_Req = 1'b1; Ld_Addr = 32'h0000_000E;
      #1 check("t2_ld_hit_c", 32'(Stall), 32'd1);
      Ld_Req = 1'b0;
      store(32'h0000_000C, 32'h0000_5500, 4'h2, 32'h2F0);
      #1 check("t2_merge_full_nostall", 32'(Stall), 32'd0);
      step();
      store(32'h10, 32'hE4, 4'hF, 32'h210);
      #1 check("t2_full_stall", 32'(Stall), 32'd1);
      step();
      check("t2_still_full", 32'(Full), 32'd1);
      check("t2_head_held",  DM_Addr, 32'h0);
      check("t2_head_data",  DM_Data, 32'hA0);
      DM_Ready = 1'b1;
      #1 check("t2_drain_nostall", 32'(Stall), 32'd0);
      step();
      St_Req = 1'b0;
      exp_addr[0] = 32'h4;  exp_data[0] = 32'hA1;
      exp_addr[1] = 32'h8;  exp_data[1] = 32'hA2;
      exp_addr[2] = 32'hC;  exp_data[2] = 32'h55A3;
      exp_addr[3] = 32'h10; exp_data[3] = 32'hE4;
      check("t2_full_after_swap", 32'(Full), 32'd1);
      for (int k = 0; k < 4; k++) begin
         check($sformatf("t2_order_addr%0d", k), DM_Addr, exp_addr[k]);
         check($sformatf("t2_order_data%0d", k), DM_Data, exp_data[k]);
         step();
      end
      check("t2_empty", 32'(Empty), 32'd1);

      // Byte merge into the newest entry
      DM_Ready = 1'b0;
      store(32'h20, 32'h0000_00AA, 4'h1, 32'h300);
      step();
      store(32'h21, 32'h0000_BB00, 4'h2, 32'h304);
      step();
      St_Req = 1'b0;
      check("t3_addr", DM_Addr, 32'h20);
      check("t3_be",   32'(DM_BE), 32'h3);
      check("t3_data", DM_Data & 32'h0000_FFFF, 32'h0000_BBAA);
      check("t3_pc",   DM_PC, 32'h304);
      DM_Ready = 1'b1;
      step();
      check("t3_one_entry", 32'(Empty), 32'd1);

      // Load hazard against a queued word
      DM_Ready = 1'b0;
      store(32'h40, 32'hCAFE_F00D, 4'hF, 32'h400);
      step();
      St_Req = 1'b0;
      Ld_Req = 1'b1; Ld_Addr = 32'h44;
      #1 check("t4_ld_miss", 32'(Stall), 32'd0);
      Ld_Addr = 32'h42;
      #1 check("t4_ld_hit", 32'(Stall), 32'd1);
      DM_Ready = 1'b1;
      #1 check("t4_ld_hit_draining", 32'(Stall), 32'd1);
      step();
      check("t4_ld_clear", 32'(Stall), 32'd0);
      check("t4_empty",    32'(Empty), 32'd1);
      Ld_Req = 1'b0;

      // Same word as a single entry that drains this cycle: allocate, not merge
      DM_Ready = 1'b0;
      store(32'h50, 32'h1111_1111, 4'hF, 32'h500);
      step();
      DM_Ready = 1'b1;
      store(32'h50, 32'h0000_0022, 4'h1, 32'h504);
      #1 check("t5_head_data", DM_Data, 32'h1111_1111);
      step();
      St_Req = 1'b0; DM_Ready = 1'b0;
      check("t5_wr",   32'(DM_Wr), 32'd1);
      check("t5_addr", DM_Addr, 32'h50);
      check("t5_be",   32'(DM_BE), 32'h1);
      check("t5_data", DM_Data, 32'h0000_0022);
      check("t5_pc",   DM_PC, 32'h504);
      DM_Ready = 1'b1;
      step();
      check("t5_empty", 32'(Empty), 32'd1);

      // Asynchronous reset with three entries queued
      DM_Ready = 1'b0;
      for (int k = 0; k < 3; k++) begin
         store(32'h60 + 32'(4*k), 32'h600 + 32'(k), 4'hF, 32'h600);
         step();
      end
      St_Req = 1'b0;
      check("t6_pre_nonempty", 32'(Empty), 32'd0);
      #2 Reset = 1'b1;
      #1;
      check("t6_async_empty", 32'(Empty), 32'd1);
      check("t6_async_wr",    32'(DM_Wr), 32'd0);
      check("t6_async_be",    32'(DM_BE), 32'd0);
      step(); step();
      Reset = 1'b0;
      DM_Ready = 1'b1;
      for (int k = 0; k < 3; k++) begin
         #1 check($sformatf("t6_no_wr%0d", k), 32'(DM_Wr), 32'd0);
         step();
      end

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

endmodule

// File: doc/m_store_buffer.md
Name: m_store_buffer

Overview:
- Write-posting store buffer in the M stage, directly upstream of the data memory.
- Accepts store requests from the M-stage pipeline, queues them in order, and drains one per accepted cycle into the DM write port.
- Byte stores to the newest queued word are merged into that entry.
- Raises a stall when it is full, or when a load targets a word that is still queued.

Parameters:
- DEPTH, 4, number of queue entries; power of two, minimum 2.
- PTR_W, 2, pointer width; equals log2(DEPTH).

Ports:
- Clk  in  1  system clock, rising edge.
- Reset  in  1  asynchronous, active-high reset.
- St_Req  in  1  M-stage store valid this cycle.
- St_Addr  in  32  store byte address; word address is St_Addr[31:2].
- St_Data  in  32  store data, already lane-aligned.
- St_BE  in  4  byte enables; bit i covers byte lane i.
- St_PC  in  32  PC of the store instruction.
- Ld_Req  in  1  M-stage load valid this cycle.
- Ld_Addr  in  32  load byte address.
- DM_Ready  in  1  DM accepts the head entry this cycle.
- DM_Wr  out  1  head entry valid toward DM.
- DM_Addr  out  32  head word address, {addr[31:2],2'b00}.
- DM_Data  out  32  head data.
- DM_BE  out  4  head byte enables.
- DM_PC  out  32  PC of the last store merged into the head entry.
- Stall  out  1  freeze the F/D/E/M pipeline this cycle.
- Empty  out  1  count == 0.
- Full  out  1  count == DEPTH.

Behaviour:
- State: entry arrays (word addr[31:2], data, BE, PC), head ptr, tail ptr, count (PTR_W+1 bits).
- Reset: all pointers and count go to 0 immediately, all entry BE go to 0. DM_Wr=0, Stall=0, Empty=1, Full=0. DM_Addr/Data/BE/PC read the head entry; only BE is defined as 0 after reset.
- Reset mid-drain: all queued stores are discarded. The DM write of the cycle in which Reset rises is not guaranteed.
- Drain (combinational outputs): DM_Wr = !Empty; DM_* come from the head entry.
- Drain (clocked): on a rising edge with DM_Wr && DM_Ready, head advances by 1 modulo DEPTH and count decrements.
- Enqueue accept: St_Req && (!Full || drain this cycle).
- Merge: applies if count ≥ 1, St_Addr[31:2] equals the tail-1 entry's word address, and NOT (count==1 && drain this cycle). On merge:
  - for each lane i with St_BE[i]=1, entry data byte i takes St_Data byte i;
  - entry BE |= St_BE;
  - entry PC = St_PC;
  - count is unchanged.
- Allocate (otherwise): write the tail entry, tail advances modulo DEPTH, count increments.
- Simultaneous drain and allocate: count is unchanged, both pointers advance.
- Full with no drain: the store is not accepted and Stall asserts. The merge path is still taken when it applies, since it needs no slot.
- Load hazard: Ld_Req asserted and Ld_Addr[31:2] matches any valid entry (comparison includes the entry currently draining) → Stall=1. No data forwarding is done.
- Stall = (St_Req && Full && !drain && !merge) || load_hazard. Purely combinational, same cycle.
- St_Req and Ld_Req are never both set; if they are, the store is processed and the load hazard is still reported.
- Pointer wrap: tail DEPTH-1 → 0 and head DEPTH-1 → 0. count distinguishes full from empty.
- Latency: an accepted store is visible on DM_Wr the next cycle when the queue was empty; there is no combinational bypass from St_* to DM_*.
- Ordering: DM sees stores in program order. Merged stores keep the entry's original position.
- St_BE = 0 is treated as no store; the block neither allocates nor merges.

Test Plan:
- Reset, then St_Req for addr 0x0000_0010, data 0x1234_5678, BE 4'hF; DM_Ready=1 → next cycle DM_Wr=1, DM_Addr=0x10, DM_Data=0x12345678, DM_BE=4'hF. The cycle after: Empty=1.
- DM_Ready=0, four stores to 0x0, 0x4, 0x8, 0xC → Full=1. A fifth store to 0x10 → Stall=1, count stays 4. Raise DM_Ready for one cycle → store accepted, Stall=0. Drain order is 0x0, 0x4, 0x8, 0xC, 0x10 (tail wraps to 0).
- DM_Ready=0: store 0x20 with BE 4'h1, data 0x0000_00AA, then store 0x21 with BE 4'h2, data 0x0000_BB00 → one entry, BE 4'h3, data low half 0xBBAA, PC equals the second store's PC.
- Entry queued at 0x40, DM_Ready=0, Ld_Req to 0x42 → Stall=1. Raise DM_Ready → entry drains, Stall=0 the following cycle. Ld_Req to 0x44 while 0x40 is queued → Stall=0.
- count=1 at 0x50 draining this cycle and St_Req to 0x50 → allocates a new entry; the next cycle shows DM_Wr=1 at 0x50 with only the second store's BE/data.
- Three entries queued, assert Reset asynchronously between clock edges → Empty=1, DM_Wr=0 immediately, no further DM writes after release.
